load_extract_unit: RTL
======================

Name: load_extract_unit

Overview:
- Multi-cycle load-data unit between the M stage and the data bus.
- Accepts one load request at a time. Checks alignment and address range, drives a word/doubleword-aligned bus read with byte enables, and waits for the bus acknowledge, bounded by a timeout.
- Extracts the byte, halfword, word or doubleword with sign/zero extension and holds the result until the pipeline accepts it.
- Generalises the single-width combinational extractor with a parametrised data width, unsigned loads, a configurable device window, wait states and exception reporting.

Parameters:
- DATA_W, 32, bus/result width; legal values 32 or 64.
- DM_LIMIT, 32'h0000_3000, data memory occupies [0, DM_LIMIT).
- DEV_BASE, 32'h0000_7F00, start of device window (inclusive).
- DEV_LIMIT, 32'h0000_7F30, end of device window (exclusive).
- TIMEOUT, 16, maximum cycles spent in WAIT before aborting; must be ≥1.

Ports:
- clk  in  1  clock; all flops are rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD; 7 is reserved.
- bus_req  out  1  bus read strobe.
- bus_addr  out  32  address aligned to DATA_W/8.
- bus_be  out  DATA_W/8  byte enables.
- bus_rdata  in  DATA_W  read data.
- bus_ack  in  1  bus_rdata is valid this cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  extended result.
- rsp_exc  out  2  0 none, 1 AdEL (misaligned, or op illegal for the width), 2 out of range, 3 bus timeout.

Behaviour:
- Reset (async, reset=0) forces:
  - state=IDLE;
  - req_ready=1, bus_req=0, bus_addr=0, bus_be=0;
  - rsp_valid=0, rsp_data=0, rsp_exc=0;
  - timeout counter=0.
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A handshake occurs when req_valid&req_ready; the unit then latches addr and op.
  - A request raises an exception when any of the following holds:
    - it is misaligned: LH/LHU with addr[0]≠0, LW/LWU with addr[1:0]≠0, or LD with addr[2:0]≠0;
    - op is 7;
    - op is LWU or LD while DATA_W=32;
    - the address is outside both windows [0,DM_LIMIT) and [DEV_BASE,DEV_LIMIT).
  - Check priority: AdEL before range.
  - On an exception the next state is RESP with rsp_data=0, the matching rsp_exc, and no bus_req.
  - Otherwise the next state is WAIT, with registered outputs:
    - bus_req=1;
    - bus_addr = addr with its low log2(DATA_W/8) bits cleared;
    - bus_be = ones over the accessed bytes at offset addr[log2(DATA_W/8)-1:0].
  - Earliest bus_req is the cycle after the handshake.
- WAIT:
  - bus_req, bus_addr and bus_be stay stable.
  - The timeout counter increments each cycle bus_ack=0.
  - When bus_ack=1, the unit samples bus_rdata, extracts the result, drops bus_req, and enters RESP with rsp_exc=0.
  - Extraction rules:
    - the selected lane is rdata[8*off +: size];
    - LB/LH/LW sign-extend to DATA_W;
    - LBU/LHU/LWU zero-extend;
    - LD is a pass-through.
  - If the counter reaches TIMEOUT with no ack: drop bus_req, enter RESP with rsp_exc=3 and rsp_data=0.
  - If ack and timeout coincide, the ack wins.
  - An ack arriving while not in WAIT is ignored.
- RESP:
  - rsp_valid=1, and rsp_data/rsp_exc are held stable.
  - rsp_valid&rsp_ready moves the FSM to IDLE, clears rsp_valid and the counter.
  - There is no back-to-back bypass: req_ready is 1 only in IDLE.
- Minimum latency from request handshake to rsp_valid:
  - an exception path gives rsp_valid 1 cycle after the handshake;
  - a bus path with ack in the first WAIT cycle gives rsp_valid 2 cycles after the handshake.
- Asserting reset in any state aborts immediately: the bus request drops asynchronously and any pending result is discarded.

Test Plan:
- DATA_W=32, LB addr=0x0000_0003, ack in the first WAIT cycle, rdata=0x80FF_1234:
  - bus_addr=0x0, bus_be=4'b1000;
  - rsp_data=0xFFFF_FF80, rsp_exc=0, rsp_valid 2 cycles after the handshake.
- LHU addr=0x2, rdata=0x8001_0000, ack after 3 wait cycles → rsp_data=0x0000_8001. A second LHU whose addr=0x1 is accepted only after rsp_ready → exc=1, no bus_req.
- LW addr=0x0000_4000 (between DM and device windows) → rsp_exc=2, bus_req never asserted. LW addr=0x0000_7F04 with rdata=0x1234_5678 → rsp_data=0x1234_5678.
- TIMEOUT=16, no bus_ack:
  - bus_req stays high 16 cycles, then drops;
  - rsp_exc=3, rsp_data=0;
  - holding rsp_ready=0 for 5 cycles keeps rsp_valid=1 with the outputs stable.
- DATA_W=64:
  - LD addr=0x8, rdata=0xDEAD_BEEF_0123_4567 → rsp_data equal to rdata, bus_be=8'hFF;
  - LWU addr=0xC, same rdata → 0x0000_0000_DEAD_BEEF;
  - LD addr=0x4 → exc=1.
- Drive reset low mid-WAIT with bus_req=1: bus_req, rsp_valid and rsp_exc go to 0 at once and req_ready=1. A late bus_ack after reset release is ignored.

Source files
------------

// File: rtl/load_extract_unit.sv
// Multi-cycle load unit: validates a load, issues one aligned bus read,
// extracts and extends the addressed lane, and holds the result until accepted.
module load_extract_unit #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] DM_LIMIT  = 32'h0000_3000,
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter logic [31:0] DEV_LIMIT = 32'h0000_7F30,
  parameter int          TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [2:0]          req_op,
  output logic                bus_req,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_exc,
  output logic [1:0]          dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is stable while valid.
  state_t              r_state, w_state_nxt;
  logic [2:0]          r_op, w_op_nxt;
  logic [OFF_W-1:0]    r_off, w_off_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_bus_req, w_bus_req_nxt;
  logic [31:0]         r_bus_addr, w_bus_addr_nxt;
  logic [BE_W-1:0]     r_bus_be, w_bus_be_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic [1:0]          r_rsp_exc, w_rsp_exc_nxt;

  logic                w_adel, w_in_range;
  logic [BE_W-1:0]     w_mask, w_be;
  logic [DATA_W-1:0]   w_lane, w_ext;

  always_comb begin
    w_adel = 1'b0;
    case (req_op)
      3'd2, 3'd3: w_adel = req_addr[0];
      3'd4:       w_adel = |req_addr[1:0];
      3'd5:       w_adel = (|req_addr[1:0]) || (DATA_W == 32);
      3'd6:       w_adel = (|req_addr[2:0]) || (DATA_W == 32);
      3'd7:       w_adel = 1'b1;
      default:    w_adel = 1'b0;
    endcase
  end

  assign w_in_range = (req_addr < DM_LIMIT) ||
                      ((req_addr >= DEV_BASE) && (req_addr < DEV_LIMIT));

  always_comb begin
    case (req_op)
      3'd0, 3'd1: w_mask = BE_W'(8'h01);
      3'd2, 3'd3: w_mask = BE_W'(8'h03);
      3'd4, 3'd5: w_mask = BE_W'(8'h0F);
      default:    w_mask = BE_W'(8'hFF);
    endcase
  end

  assign w_be = w_mask << req_addr[OFF_W-1:0];

  // Shift the addressed lane down to bit 0, then extend from the access size.
  assign w_lane = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_op)
      3'd0:    w_ext = DATA_W'($signed(w_lane[7:0]));
      3'd1:    w_ext = DATA_W'(w_lane[7:0]);
      3'd2:    w_ext = DATA_W'($signed(w_lane[15:0]));
      3'd3:    w_ext = DATA_W'(w_lane[15:0]);
      3'd4:    w_ext = DATA_W'($signed(w_lane[31:0]));
      3'd5:    w_ext = DATA_W'(w_lane[31:0]);
      default: w_ext = w_lane;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_off_nxt       = r_off;
    w_cnt_nxt       = r_cnt;
    w_bus_req_nxt   = r_bus_req;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_be_nxt    = r_bus_be;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_exc_nxt   = r_rsp_exc;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_op_nxt  = req_op;
          w_off_nxt = req_addr[OFF_W-1:0];
          w_cnt_nxt = '0;
          if (w_adel || !w_in_range) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_exc_nxt   = w_adel ? 2'd1 : 2'd2;
          end else begin
            w_state_nxt    = S_WAIT;
            w_bus_req_nxt  = 1'b1;
            w_bus_addr_nxt = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            w_bus_be_nxt   = w_be;
          end
        end
      end
      S_WAIT: begin
        // An ack in the final allowed cycle still completes the load.
        if (bus_ack) begin
          w_state_nxt     = S_RESP;
          w_bus_req_nxt   = 1'b0;
          w_bus_addr_nxt  = '0;
          w_bus_be_nxt    = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_ext;
          w_rsp_exc_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_state_nxt     = S_RESP;
            w_bus_req_nxt   = 1'b0;
            w_bus_addr_nxt  = '0;
            w_bus_be_nxt    = '0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_exc_nxt   = 2'd3;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_off       <= '0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_exc   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_off       <= w_off_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_be    <= w_bus_be_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_exc   <= w_rsp_exc_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign bus_req   = r_bus_req;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_exc   = r_rsp_exc;
  assign dbg_state = r_state;

endmodule
